// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction codes, exception codes, MEM stage state
// encoding and small opcode classification helpers.
package mips_pkg;

  localparam logic [7:0] INST_NOP  = 8'h00;
  localparam logic [7:0] INST_ADDU = 8'h01;
  localparam logic [7:0] INST_SUBU = 8'h02;
  localparam logic [7:0] INST_AND  = 8'h03;
  localparam logic [7:0] INST_OR   = 8'h04;
  localparam logic [7:0] INST_LUI  = 8'h05;
  localparam logic [7:0] INST_BEQ  = 8'h10;
  localparam logic [7:0] INST_BNE  = 8'h11;
  localparam logic [7:0] INST_LB   = 8'h20;
  localparam logic [7:0] INST_LBU  = 8'h21;
  localparam logic [7:0] INST_LH   = 8'h22;
  localparam logic [7:0] INST_LHU  = 8'h23;
  localparam logic [7:0] INST_LW   = 8'h24;
  localparam logic [7:0] INST_SB   = 8'h28;
  localparam logic [7:0] INST_SH   = 8'h29;
  localparam logic [7:0] INST_SW   = 8'h2A;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  function automatic logic is_load(input logic [7:0] op);
    return op inside {INST_LB, INST_LBU, INST_LH, INST_LHU, INST_LW};
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return op inside {INST_SB, INST_SH, INST_SW};
  endfunction

  function automatic logic is_branch(input logic [7:0] op);
    return op inside {INST_BEQ, INST_BNE};
  endfunction

  function automatic logic is_half(input logic [7:0] op);
    return op inside {INST_LH, INST_LHU, INST_SH};
  endfunction

  function automatic logic is_word(input logic [7:0] op);
    return op inside {INST_LW, INST_SW};
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data formatter: picks the addressed byte/halfword out of the SRAM word
// and sign- or zero-extends it according to the load opcode.
module mem_load_align
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [7:0]  op,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[7:0];
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (addr_lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase

    result = rdata;
    case (op)
      INST_LB:  result = {{24{byte_v[7]}}, byte_v};
      INST_LBU: result = {24'h000000, byte_v};
      INST_LH:  result = {{16{half_v[15]}}, half_v};
      INST_LHU: result = {16'h0000, half_v};
      default:  result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM pipeline stage: drives the data SRAM, waits out the read latency and
// registers the writeback result. Define MEM_ADDR_EXC_EN for AdEL/AdES traps.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_inst_name,
  input  logic [31:0]       in_aluResult,
  input  logic [31:0]       in_readData2,
  input  logic [4:0]        in_writeDataReg,
  input  logic [31:0]       in_fourPC,
  output logic              stall,
  output logic              data_sram_en,
  output logic [3:0]        data_sram_wen,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [31:0]       data_sram_wdata,
  input  logic [31:0]       data_sram_rdata,
  output logic              out_valid,
  output logic [31:0]       out_wbData,
  output logic [4:0]        out_writeDataReg,
  output logic              out_regWrite,
  output logic [31:0]       out_fourPC,
  output logic [4:0]        out_excCode,
  output logic [31:0]       out_badVAddr
);

  localparam logic [1:0] LAT = 2'(RD_LATENCY);

  mem_state_e  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [7:0]  op_q, op_d;
  logic [4:0]  dest_q, dest_d;
  logic [31:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic        reg_write_q, reg_write_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wr_reg_q, wr_reg_d;
  logic [31:0] out_pc_q, out_pc_d;
`ifdef MEM_ADDR_EXC_EN
  logic [4:0]  exc_q, exc_d;
  logic [31:0] bad_q, bad_d;
`endif

  logic [1:0]  off;
  logic        misaligned;
  logic [31:0] load_data;

  assign off = in_aluResult[1:0];

`ifdef MEM_ADDR_EXC_EN
  assign misaligned = (is_half(in_inst_name) && off[0]) ||
                      (is_word(in_inst_name) && (off != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  mem_load_align u_load_align (
    .rdata   (data_sram_rdata),
    .addr_lo (addr_lo_q),
    .op      (op_q),
    .result  (load_data)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    addr_lo_d       = addr_lo_q;
    op_d            = op_q;
    dest_d          = dest_q;
    pc_d            = pc_q;
    out_valid_d     = 1'b0;
    reg_write_d     = reg_write_q;
    wb_data_d       = wb_data_q;
    wr_reg_d        = wr_reg_q;
    out_pc_d        = out_pc_q;
`ifdef MEM_ADDR_EXC_EN
    exc_d           = exc_q;
    bad_d           = bad_q;
`endif
    stall           = 1'b0;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'b0000;
    data_sram_addr  = '0;
    data_sram_wdata = 32'h0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (!is_load(in_inst_name) || misaligned) begin
            wb_data_d = in_aluResult;
            wr_reg_d  = in_writeDataReg;
            out_pc_d  = in_fourPC;
`ifdef MEM_ADDR_EXC_EN
            exc_d     = EXC_NONE;
            bad_d     = 32'h0;
`endif
          end
          if (misaligned) begin
            out_valid_d = 1'b1;
            reg_write_d = 1'b0;
`ifdef MEM_ADDR_EXC_EN
            exc_d       = is_load(in_inst_name) ? EXC_ADEL : EXC_ADES;
            bad_d       = in_aluResult;
`endif
          end else if (is_store(in_inst_name)) begin
            data_sram_en   = 1'b1;
            data_sram_addr = {in_aluResult[ADDR_W-1:2], 2'b00};
            case (in_inst_name)
              INST_SB: begin
                data_sram_wen   = 4'b0001 << off;
                data_sram_wdata = {4{in_readData2[7:0]}};
              end
              INST_SH: begin
                data_sram_wen   = 4'b0011 << {off[1], 1'b0};
                data_sram_wdata = {2{in_readData2[15:0]}};
              end
              default: begin
                data_sram_wen   = 4'b1111;
                data_sram_wdata = in_readData2;
              end
            endcase
            out_valid_d = 1'b1;
            reg_write_d = 1'b0;
          end else if (is_load(in_inst_name)) begin
            data_sram_en   = 1'b1;
            data_sram_addr = {in_aluResult[ADDR_W-1:2], 2'b00};
            stall          = 1'b1;
            addr_lo_d      = off;
            op_d           = in_inst_name;
            dest_d         = in_writeDataReg;
            pc_d           = in_fourPC;
            cnt_d          = LAT;
            state_d        = ST_WAIT;
          end else begin
            out_valid_d = 1'b1;
            reg_write_d = !is_branch(in_inst_name) && (in_writeDataReg != 5'd0);
          end
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        // Read data is valid only in the last counted cycle; upstream advances here.
        if (cnt_q == 2'd1) begin
          out_valid_d = 1'b1;
          reg_write_d = (dest_q != 5'd0);
          wb_data_d   = load_data;
          wr_reg_d    = dest_q;
          out_pc_d    = pc_q;
`ifdef MEM_ADDR_EXC_EN
          exc_d       = EXC_NONE;
          bad_d       = 32'h0;
`endif
          state_d     = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A request coinciding with reset must not reach the SRAM or hold the pipe.
    if (rst) begin
      stall           = 1'b0;
      data_sram_en    = 1'b0;
      data_sram_wen   = 4'b0000;
      data_sram_addr  = '0;
      data_sram_wdata = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      addr_lo_q   <= 2'd0;
      op_q        <= INST_NOP;
      dest_q      <= 5'd0;
      pc_q        <= 32'h0;
      out_valid_q <= 1'b0;
      reg_write_q <= 1'b0;
      wb_data_q   <= 32'h0;
      wr_reg_q    <= 5'd0;
      out_pc_q    <= 32'h0;
`ifdef MEM_ADDR_EXC_EN
      exc_q       <= EXC_NONE;
      bad_q       <= 32'h0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_lo_q   <= addr_lo_d;
      op_q        <= op_d;
      dest_q      <= dest_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      reg_write_q <= reg_write_d;
      wb_data_q   <= wb_data_d;
      wr_reg_q    <= wr_reg_d;
      out_pc_q    <= out_pc_d;
`ifdef MEM_ADDR_EXC_EN
      exc_q       <= exc_d;
      bad_q       <= bad_d;
`endif
    end
  end

  assign out_valid        = out_valid_q;
  assign out_regWrite     = reg_write_q;
  assign out_wbData       = wb_data_q;
  assign out_writeDataReg = wr_reg_q;
  assign out_fourPC       = out_pc_q;
`ifdef MEM_ADDR_EXC_EN
  assign out_excCode      = exc_q;
  assign out_badVAddr     = bad_q;
`else
  assign out_excCode      = EXC_NONE;
  assign out_badVAddr     = 32'h0;
`endif

endmodule
